divider_iterative: RTL
======================

DIVIDER_ITERATIVE -- requirements
Module: divider_iterative

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port startE  input  1  request a new division; sampled only in IDLE.
REQ-005 SHALL have port div_opcode  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port operand1  input  XLEN  dividend.
REQ-007 SHALL have port operand2  input  XLEN  divisor.
REQ-008 SHALL have port result_divide  output  XLEN  quotient or remainder, registered.
REQ-009 SHALL have port ready  output  1  one-cycle pulse, result_divide valid.
REQ-010 SHALL have port busy  output  1  high in CALC and DONE.

Function
REQ-011 SHALL implement FSM with states IDLE, CALC and DONE.
REQ-012 IDLE with startE=1 at a rising edge SHALL latch div_opcode and operand magnitudes plus sign flags, load counter=XLEN and go to CALC.
REQ-013 CALC SHALL perform one restoring shift-subtract step per cycle, decrement the counter, and go to DONE after XLEN steps.
REQ-014 DONE SHALL drive ready=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-015 Latency SHALL be: start edge k -> ready high in the cycle after edge k+XLEN (33 cycles for XLEN=32).
REQ-016 startE SHALL be ignored while busy=1; no queuing, no abort.
REQ-017 result_divide SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-018 Signed ops (DIV, REM) SHALL divide magnitudes: quotient negated iff operand signs differ; remainder takes the sign of the dividend.
REQ-019 Divisor 0 SHALL give quotient 0xFFFFFFFF (DIV, DIVU) and remainder = operand1 (REM, REMU).
REQ-020 DIV with 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000; REM SHALL give 0.
REQ-021 Results for REQ-019/REQ-020 SHALL be forced by final correction, independent of the iteration datapath.
REQ-022 Operand inputs SHALL be don't-care after the start edge; the latched copies are used.

Reset
REQ-023 rst=1 at a rising edge SHALL set state=IDLE, counter=0, result_divide=0, ready=0, busy=0.
REQ-024 rst during CALC or DONE SHALL abort the operation with no ready pulse.
REQ-025 rst and startE high in the same cycle: rst SHALL win; no operation starts.

Configuration
REQ-026 Macro DIV_FAST_PATH_EN defined: divisor-zero and signed-overflow cases SHALL go IDLE->DONE directly, with ready in the cycle after the start edge.
REQ-027 Macro DIV_FAST_PATH_EN undefined: all cases SHALL take the full XLEN-step latency, with results still per REQ-019/REQ-020.

Verification
REQ-028 DIVU 100/7, start at edge 0 -> ready pulse after edge 32, result 14; REMU same operands -> 2.
REQ-029 DIV 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2 (-14); REM -> 0xFFFFFFFE (-2).
REQ-030 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; with DIV_FAST_PATH_EN, ready after 1 cycle, else after 33.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; latency per macro as in REQ-030.
REQ-032 startE pulsed again at CALC cycle 10 with new operands -> ignored; first result is delivered unchanged and only one ready pulse occurs.
REQ-033 rst asserted at CALC cycle 20 -> next cycle busy=0, result_divide=0, no ready pulse; a new start then completes normally.

Source files
------------

// File: rtl/divider_iterative.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle, XLEN steps.
// Optional macro DIV_FAST_PATH_EN: divisor-zero and signed-overflow results skip the iteration.
module divider_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startE,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_divide,
    output logic            ready,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshake: startE is sampled only in IDLE; ready is a one-cycle pulse
    // in DONE that qualifies result_divide, and busy covers CALC and DONE.

    logic [1:0]      state;
    logic [CW-1:0]   counter;
    logic [1:0]      op_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] op1_q;
    logic            negq_q;
    logic            negr_q;
    logic            dz_q;
    logic            ov_q;

    // Decode of the live inputs, only meaningful on the start edge.
    logic            s1_in;
    logic            s2_in;
    logic [XLEN-1:0] mag1_in;
    logic [XLEN-1:0] mag2_in;
    logic            dz_in;
    logic            ov_in;

    always_comb begin
        s1_in   = ~div_opcode[0] & operand1[XLEN-1];
        s2_in   = ~div_opcode[0] & operand2[XLEN-1];
        mag1_in = s1_in ? -operand1 : operand1;
        mag2_in = s2_in ? -operand2 : operand2;
        dz_in   = (operand2 == '0);
        ov_in   = ~div_opcode[0] & (operand1 == {1'b1, {(XLEN-1){1'b0}}}) & (operand2 == '1);
    end

    // One restoring step: shift the next dividend bit into the partial remainder,
    // subtract the divisor, and keep the difference only when it did not borrow.
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
        rem_next  = diff[XLEN+1] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], ~diff[XLEN+1]};
    end

    // Sign fix-up, then the special cases override whatever the datapath produced.
    function automatic logic [XLEN-1:0] finalize(
        input logic [1:0]      op,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            nq,
        input logic            nr,
        input logic            dz,
        input logic            ov,
        input logic [XLEN-1:0] a
    );
        logic [XLEN-1:0] res;
        if (op[1]) res = nr ? -r : r;
        else       res = nq ? -q : q;
        if (dz)      res = op[1] ? a : '1;
        else if (ov) res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            counter       <= '0;
            result_divide <= '0;
            op_q          <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            op1_q         <= '0;
            negq_q        <= 1'b0;
            negr_q        <= 1'b0;
            dz_q          <= 1'b0;
            ov_q          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (startE) begin
                        op_q    <= div_opcode;
                        quo_q   <= mag1_in;
                        rem_q   <= '0;
                        dvs_q   <= mag2_in;
                        op1_q   <= operand1;
                        negq_q  <= s1_in ^ s2_in;
                        negr_q  <= s1_in;
                        dz_q    <= dz_in;
                        ov_q    <= ov_in;
                        counter <= CW'(XLEN);
`ifdef DIV_FAST_PATH_EN
                        if (dz_in || ov_in) begin
                            state         <= S_DONE;
                            counter       <= '0;
                            result_divide <= finalize(div_opcode, '0, '0, 1'b0, 1'b0,
                                                      dz_in, ov_in, operand1);
                        end else begin
                            state <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    counter <= counter - 1'b1;
                    rem_q   <= rem_next;
                    quo_q   <= quo_next;
                    if (counter == CW'(1)) begin
                        state         <= S_DONE;
                        result_divide <= finalize(op_q, quo_next, rem_next, negq_q, negr_q,
                                                  dz_q, ov_q, op1_q);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_DONE);
    assign busy  = (state != S_IDLE);

endmodule
